// File: rtl/gain_applier.sv
// Applies a slew-limited Q8.8 gain to two 14-bit ADC channels. Gain changes wait
// for a phase boundary. Output is saturated and sent on a valid/ready stream.
module gain_applier #(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int AXIS_DATA_SIZE   = 32,
  parameter int ZMOD_DATA_SIZE   = 14,
  parameter int QUOTIENT_SIZE    = 8,
  parameter int FRACTIONAL_SIZE  = 8,
  parameter int RAMP_STEP        = 16,
  parameter logic [IAGC_STATUS_SIZE-1:0] STATUS_BYPASS = 4'd0,
  parameter logic [IAGC_STATUS_SIZE-1:0] STATUS_RUN    = 4'd3
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0]            i_iagcStatus,
  input  logic [QUOTIENT_SIZE-1:0]               i_quotient,
  input  logic [FRACTIONAL_SIZE-1:0]             i_fractional,
  input  logic                                   i_inPhase,
  input  logic [AXIS_DATA_SIZE-1:0]              i_adcData,
  input  logic                                   i_valid,
  input  logic                                   i_ready,
  output logic [AXIS_DATA_SIZE-1:0]              o_dacData,
  output logic                                   o_valid,
  output logic [QUOTIENT_SIZE+FRACTIONAL_SIZE-1:0] o_gain,
  output logic                                   o_saturated,
  output logic                                   o_overflow
);

  localparam int GAIN_SIZE    = QUOTIENT_SIZE + FRACTIONAL_SIZE;
  localparam int PRODUCT_SIZE = ZMOD_DATA_SIZE + GAIN_SIZE + 1;
  localparam int HALF_SIZE    = AXIS_DATA_SIZE / 2;
  localparam int PAD_SIZE     = HALF_SIZE - ZMOD_DATA_SIZE;

  localparam logic [GAIN_SIZE-1:0] UNITY_GAIN = GAIN_SIZE'(1) << FRACTIONAL_SIZE;
  localparam logic [GAIN_SIZE-1:0] STEP_LIMIT = GAIN_SIZE'(RAMP_STEP);
  localparam logic signed [PRODUCT_SIZE-1:0] SAT_MAX =
    PRODUCT_SIZE'((2 ** (ZMOD_DATA_SIZE - 1)) - 1);
  localparam logic signed [PRODUCT_SIZE-1:0] SAT_MIN =
    PRODUCT_SIZE'(-(2 ** (ZMOD_DATA_SIZE - 1)));

  typedef enum logic [1:0] {IDLE, ARMED, RAMP} gainState_e;

  typedef struct packed {
    logic                      clipped;
    logic [ZMOD_DATA_SIZE-1:0] value;
  } clipResult_t;

  function automatic logic signed [PRODUCT_SIZE-1:0] scaleSample(
    input logic signed [ZMOD_DATA_SIZE-1:0] sample,
    input logic        [GAIN_SIZE-1:0]      gain
  );
    logic signed [PRODUCT_SIZE-1:0] sampleWide;
    logic signed [PRODUCT_SIZE-1:0] gainWide;
    sampleWide = PRODUCT_SIZE'(sample);
    gainWide   = $signed(PRODUCT_SIZE'(gain));
    return sampleWide * gainWide;
  endfunction

  function automatic clipResult_t clipSample(input logic signed [PRODUCT_SIZE-1:0] product);
    logic signed [PRODUCT_SIZE-1:0] shifted;
    clipResult_t result;
    shifted = product >>> FRACTIONAL_SIZE;
    result.clipped = 1'b1;
    if (shifted > SAT_MAX) begin
      result.value = SAT_MAX[ZMOD_DATA_SIZE-1:0];
    end else if (shifted < SAT_MIN) begin
      result.value = SAT_MIN[ZMOD_DATA_SIZE-1:0];
    end else begin
      result.clipped = 1'b0;
      result.value   = shifted[ZMOD_DATA_SIZE-1:0];
    end
    return result;
  endfunction

  // ---------------------------------------------------------------- handshake
  logic s1Valid;
  logic outAdvance;
  logic s1Advance;
  logic sampleAccepted;

  assign outAdvance     = !o_valid || i_ready;
  assign s1Advance      = !s1Valid || outAdvance;
  assign sampleAccepted = i_valid && s1Advance;

  // ---------------------------------------------------------------- gain control
  gainState_e           state, stateNext;
  logic [GAIN_SIZE-1:0] target, targetNext, gainNext;
  logic [GAIN_SIZE-1:0] targetIn;
  logic [GAIN_SIZE-1:0] gainDistance, gainStep;
  logic                 targetChanged, gainBelow, inPhasePrev, phaseRise;

  assign targetIn      = {i_quotient, i_fractional};
  assign targetChanged = targetIn != target;
  assign phaseRise     = !inPhasePrev && i_inPhase;
  assign gainBelow     = o_gain < target;
  assign gainDistance  = gainBelow ? (target - o_gain) : (o_gain - target);
  assign gainStep      = (gainDistance > STEP_LIMIT) ? STEP_LIMIT : gainDistance;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    stateNext  = state;
    targetNext = target;
    gainNext   = o_gain;
    if (i_iagcStatus == STATUS_BYPASS) begin
      stateNext  = IDLE;
      targetNext = UNITY_GAIN;
      gainNext   = UNITY_GAIN;
    end else if (i_iagcStatus == STATUS_RUN) begin
      if (targetChanged) targetNext = targetIn;
      unique case (state)
        IDLE:  if (targetChanged) stateNext = ARMED;
        ARMED: if (phaseRise) stateNext = RAMP;
        RAMP: begin
          // A new target arriving exactly on arrival keeps the ramp alive.
          if (o_gain == target) begin
            if (!targetChanged) stateNext = IDLE;
          end else if (sampleAccepted) begin
            gainNext = gainBelow ? (o_gain + gainStep) : (o_gain - gainStep);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      state       <= IDLE;
      target      <= UNITY_GAIN;
      o_gain      <= UNITY_GAIN;
      inPhasePrev <= 1'b0;
    end else begin
      state       <= stateNext;
      target      <= targetNext;
      o_gain      <= gainNext;
      inPhasePrev <= i_inPhase;
    end
  end

  // ---------------------------------------------------------------- datapath
  logic signed [ZMOD_DATA_SIZE-1:0] chA, chB;
  logic signed [PRODUCT_SIZE-1:0]   s1ProdA, s1ProdB;
  clipResult_t                      clipA, clipB;

  assign chA   = i_adcData[AXIS_DATA_SIZE-1 -: ZMOD_DATA_SIZE];
  assign chB   = i_adcData[HALF_SIZE-1 -: ZMOD_DATA_SIZE];
  assign clipA = clipSample(s1ProdA);
  assign clipB = clipSample(s1ProdB);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s1Valid     <= 1'b0;
      o_valid     <= 1'b0;
      o_dacData   <= '0;
      o_saturated <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (s1Advance) begin
        s1Valid <= i_valid;
      end else if (i_valid) begin
        o_overflow <= 1'b1;
      end
      if (outAdvance) begin
        o_valid <= s1Valid;
        if (s1Valid) begin
          o_dacData <= {clipA.value, {PAD_SIZE{1'b0}}, clipB.value, {PAD_SIZE{1'b0}}};
          if (clipA.clipped || clipB.clipped) o_saturated <= 1'b1;
        end
      end
    end
  end

  // NOTE: product registers carry no reset; s1Valid qualifies them, so resetting data would only add fan-out.
  always_ff @(posedge i_clock) begin
    if (sampleAccepted) begin
      s1ProdA <= scaleSample(chA, o_gain);
      s1ProdB <= scaleSample(chB, o_gain);
    end
  end

endmodule

// File: tb/tb_gain_applier.sv
// Directed bench for gain_applier: stimulus pushes hand-computed samples into a
// scoreboard queue, a monitor pops and compares on every output transfer.
module tb_gain_applier;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [3:0]  i_iagcStatus;
  logic [7:0]  i_quotient;
  logic [7:0]  i_fractional;
  logic        i_inPhase;
  logic [31:0] i_adcData;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] o_dacData;
  logic        o_valid;
  logic [15:0] o_gain;
  logic        o_saturated;
  logic        o_overflow;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] scoreboard[$];

  gain_applier dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_iagcStatus(i_iagcStatus),
    .i_quotient  (i_quotient),
    .i_fractional(i_fractional),
    .i_inPhase   (i_inPhase),
    .i_adcData   (i_adcData),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .o_dacData   (o_dacData),
    .o_valid     (o_valid),
    .o_gain      (o_gain),
    .o_saturated (o_saturated),
    .o_overflow  (o_overflow)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic logic [31:0] pack(input int a, input int b);
    logic [13:0] ca;
    logic [13:0] cb;
    ca = a[13:0];
    cb = b[13:0];
    return {ca, 2'b00, cb, 2'b00};
  endfunction

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic pushExp(input int a, input int b);
    scoreboard.push_back(pack(a, b));
  endtask

  task automatic sendSample(input int a, input int b);
    i_adcData = pack(a, b);
    i_valid   = 1'b1;
    tick();
    i_valid   = 1'b0;
  endtask

  task automatic setGain(input logic [15:0] g);
    {i_quotient, i_fractional} = g;
  endtask

  task automatic pulsePhase();
    i_inPhase = 1'b1;
    tick();
    i_inPhase = 1'b0;
    tick();
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_valid"},     {31'd0, o_valid},     32'd0);
    check({tag, "_data"},      o_dacData,            32'd0);
    check({tag, "_gain"},      {16'd0, o_gain},      32'h0100);
    check({tag, "_saturated"}, {31'd0, o_saturated}, 32'd0);
    check({tag, "_overflow"},  {31'd0, o_overflow},  32'd0);
  endtask

  // Monitor: every transfer must match the oldest expected sample.
  always @(negedge i_clock) begin
    if (!i_reset && o_valid && i_ready) begin
      if (scoreboard.size() == 0) begin
        checkCount++;
        $display("FAIL unexpected_output: got 0x%08h, expected no transfer", o_dacData);
      end else begin
        check("sample", o_dacData, scoreboard.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Ramp 0x0100 -> 0x0180: gain after each accepted sample, and the scaled
  // values of (+100,-100) at the gain in force when each sample was accepted.
  logic [15:0] rampGain [8] = '{16'h0110, 16'h0120, 16'h0130, 16'h0140,
                                16'h0150, 16'h0160, 16'h0170, 16'h0180};
  int          rampExpA [8] = '{100, 106, 112, 118, 125, 131, 137, 143};
  int          rampExpB [8] = '{-100, -107, -113, -119, -125, -132, -138, -144};

  initial begin
    i_reset      = 1'b1;
    i_iagcStatus = 4'd3;
    setGain(16'h0100);
    i_inPhase    = 1'b0;
    i_adcData    = '0;
    i_valid      = 1'b0;
    i_ready      = 1'b1;
    tick();
    tick();
    checkResetState("reset");
    i_reset = 1'b0;
    tick();

    // Unity gain and two-cycle latency.
    pushExp(1000, -1000);
    i_adcData = pack(1000, -1000);
    i_valid   = 1'b1;
    tick();
    i_valid   = 1'b0;
    check("latency_n1_valid", {31'd0, o_valid}, 32'd0);
    tick();
    check("latency_n2_valid", {31'd0, o_valid}, 32'd1);
    check("unity_saturated", {31'd0, o_saturated}, 32'd0);

    // Deferred ramp: new target waits for a phase edge.
    setGain(16'h0180);
    tick();
    for (int k = 0; k < 20; k++) begin
      pushExp(100, -100);
      sendSample(100, -100);
    end
    check("armed_gain_held", {16'd0, o_gain}, 32'h0100);
    pulsePhase();
    for (int k = 0; k < 8; k++) begin
      pushExp(rampExpA[k], rampExpB[k]);
      sendSample(100, -100);
      check($sformatf("ramp_gain_%0d", k), {16'd0, o_gain}, {16'd0, rampGain[k]});
    end
    tick();
    pushExp(150, -150);
    sendSample(100, -100);
    check("ramp_end_gain", {16'd0, o_gain}, 32'h0180);
    // Back in IDLE, a new target must not move the gain without a phase edge.
    setGain(16'h0200);
    tick();
    pushExp(150, -150);
    sendSample(100, -100);
    check("idle_after_ramp_gain", {16'd0, o_gain}, 32'h0180);
    pulsePhase();
    for (int k = 0; k < 8; k++) begin
      pushExp(0, 0);
      sendSample(0, 0);
    end
    check("ramp_to_0200_gain", {16'd0, o_gain}, 32'h0200);
    tick();

    // Saturation boundaries at gain 2.0.
    pushExp(8190, -8192);
    sendSample(4095, -4096);
    tick();
    tick();
    check("edge_no_saturation", {31'd0, o_saturated}, 32'd0);
    pushExp(8191, -8192);
    sendSample(5000, -5000);
    tick();
    check("saturated_set", {31'd0, o_saturated}, 32'd1);
    pushExp(2, -2);
    sendSample(1, -1);
    tick();
    tick();
    check("saturated_sticky", {31'd0, o_saturated}, 32'd1);

    // Backpressure: only two samples fit, the rest are dropped.
    check("overflow_clear", {31'd0, o_overflow}, 32'd0);
    i_ready = 1'b0;
    pushExp(20, -20);
    pushExp(40, -40);
    for (int k = 1; k <= 5; k++) begin
      i_adcData = pack(10 * k, -10 * k);
      i_valid   = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    check("overflow_set", {31'd0, o_overflow}, 32'd1);
    check("stall_valid", {31'd0, o_valid}, 32'd1);
    check("stall_data", o_dacData, pack(20, -20));
    tick();
    check("stall_data_stable", o_dacData, pack(20, -20));
    i_ready = 1'b1;
    repeat (4) tick();
    check("backpressure_drain", scoreboard.size(), 32'd0);

    // Reset clears sticky flags; then bypass mid-ramp and freeze.
    i_reset = 1'b1;
    tick();
    checkResetState("reset2");
    i_reset = 1'b0;
    setGain(16'h0180);
    tick();
    pulsePhase();
    for (int k = 0; k < 4; k++) begin
      pushExp(0, 0);
      sendSample(0, 0);
    end
    check("midramp_gain", {16'd0, o_gain}, 32'h0140);
    i_iagcStatus = 4'd0;
    tick();
    check("bypass_gain", {16'd0, o_gain}, 32'h0100);
    i_iagcStatus = 4'd2;
    setGain(16'h0300);
    tick();
    pulsePhase();
    pushExp(1000, -1000);
    sendSample(1000, -1000);
    tick();
    check("frozen_gain", {16'd0, o_gain}, 32'h0100);
    tick();

    // Reset in the middle of a ramp.
    i_iagcStatus = 4'd3;
    tick();
    pulsePhase();
    for (int k = 0; k < 2; k++) begin
      pushExp(0, 0);
      sendSample(0, 0);
    end
    check("ramp2_gain", {16'd0, o_gain}, 32'h0120);
    tick();
    tick();
    i_ready = 1'b0;
    sendSample(0, 0);
    tick();
    check("pre_reset_valid", {31'd0, o_valid}, 32'd1);
    i_reset = 1'b1;
    tick();
    checkResetState("reset_midramp");
    i_ready = 1'b1;
    i_reset = 1'b0;
    repeat (3) tick();
    check("post_reset_idle_valid", {31'd0, o_valid}, 32'd0);
    pushExp(1000, -1000);
    sendSample(1000, -1000);
    check("post_reset_gain", {16'd0, o_gain}, 32'h0100);

    for (int k = 0; k < 20 && scoreboard.size() != 0; k++) tick();
    check("final_drain", scoreboard.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
